// File: rtl/cluster_ctrl_pkg.sv
// Shared constants and types for the vector-core cluster controller:
// register offsets, per-core state enum and the hard core-count ceiling.
package cluster_ctrl_pkg;

   localparam int NumCoresMax = 8;

   localparam logic [7:0] OffStart     = 8'h00;
   localparam logic [7:0] OffHalt      = 8'h04;
   localparam logic [7:0] OffStatus    = 8'h08;
   localparam logic [7:0] OffIrqState  = 8'h0C;
   localparam logic [7:0] OffIrqEnable = 8'h10;
   // Per-core window: BOOT_ADDR at base+8n, CYCLES at base+8n+4
   localparam logic [7:0] OffCoreBase  = 8'h20;

   typedef enum logic [1:0] {
      CoreIdle    = 2'd0,
      CoreHold    = 2'd1,
      CoreRunning = 2'd2,
      CoreDone    = 2'd3
   } core_state_e;

endpackage

// File: rtl/tlul_pkg.sv
// Minimal TL-UL request/response types used by the register port.
// Field set covers what a single-beat 32-bit register target needs.
package tlul_pkg;

   typedef enum logic [2:0] {
      PutFullData    = 3'h0,
      PutPartialData = 3'h1,
      Get            = 3'h4
   } tl_a_op_e;

   typedef enum logic [2:0] {
      AccessAck     = 3'h0,
      AccessAckData = 3'h1
   } tl_d_op_e;

   typedef struct packed {
      logic        a_valid;
      tl_a_op_e    a_opcode;
      logic [2:0]  a_param;
      logic [1:0]  a_size;
      logic [7:0]  a_source;
      logic [31:0] a_address;
      logic [3:0]  a_mask;
      logic [31:0] a_data;
      logic        d_ready;
   } tl_h2d_t;

   typedef struct packed {
      logic        d_valid;
      tl_d_op_e    d_opcode;
      logic [2:0]  d_param;
      logic [1:0]  d_size;
      logic [7:0]  d_source;
      logic        d_sink;
      logic [31:0] d_data;
      logic        d_error;
      logic        a_ready;
   } tl_d2h_t;

endpackage

// File: rtl/cluster_ctrl_core_fsm.sv
// Per-core sequencer: holds the core in reset for a fixed time after START,
// then counts run cycles until the core signals completion or is halted.
module cluster_ctrl_core_fsm
   import cluster_ctrl_pkg::*;
#(
   parameter int ResetHoldCycles = 16
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        start_i,
   input  logic        halt_i,
   input  logic        done_i,
   output core_state_e state_o,
   output logic        core_rst_no,
   output logic        done_evt_o,
   output logic [31:0] cycles_o
);

   localparam logic [7:0] HoldLoad = 8'(ResetHoldCycles - 1);

   core_state_e state_reg;
   logic        rst_n_reg;
   logic [7:0]  hold_cnt_reg;
   logic [31:0] cycles_reg;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_reg    <= CoreIdle;
         rst_n_reg    <= 1'b0;
         hold_cnt_reg <= '0;
         cycles_reg   <= '0;
      end else if (halt_i) begin
         state_reg <= CoreIdle;
         rst_n_reg <= 1'b0;
      end else begin
         case (state_reg)
            CoreIdle, CoreDone: begin
               if (start_i) begin
                  state_reg    <= CoreHold;
                  cycles_reg   <= '0;
                  hold_cnt_reg <= HoldLoad;
               end
            end
            CoreHold: begin
               // Counter runs HoldLoad..0, giving exactly ResetHoldCycles cycles here
               if (hold_cnt_reg == '0) begin
                  state_reg <= CoreRunning;
                  rst_n_reg <= 1'b1;
               end else begin
                  hold_cnt_reg <= hold_cnt_reg - 8'd1;
               end
            end
            CoreRunning: begin
               if (cycles_reg != '1) begin
                  cycles_reg <= cycles_reg + 32'd1;
               end
               if (done_i) begin
                  state_reg <= CoreDone;
                  rst_n_reg <= 1'b0;
               end
            end
            default: begin
               state_reg <= CoreIdle;
               rst_n_reg <= 1'b0;
            end
         endcase
      end
   end

   assign state_o     = state_reg;
   assign core_rst_no = rst_n_reg;
   assign cycles_o    = cycles_reg;
   assign done_evt_o  = (state_reg == CoreRunning) && done_i && !halt_i;

endmodule

// File: rtl/cluster_ctrl.sv
// Cluster controller: TL-UL register target that starts, halts and monitors
// up to eight vector cores and raises a completion interrupt.
module cluster_ctrl
   import cluster_ctrl_pkg::*;
   import tlul_pkg::*;
#(
   parameter int          NumCores        = 2,
   parameter int          ResetHoldCycles = 16,
   parameter logic [31:0] BootAddrDefault = 32'h0
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  tl_h2d_t                  tl_i,
   output tl_d2h_t                  tl_o,
   output logic [NumCores-1:0]      core_rst_no,
   output logic [NumCores-1:0][31:0] boot_addr_o,
   input  logic [NumCores-1:0]      core_done_i,
   output logic                     irq_o
);

   localparam logic [7:0] CoreMask = 8'((16'd1 << NumCores) - 16'd1);

   // Per-core views padded to NumCoresMax so the decoder can index by a 3-bit id
   logic [31:0]            boot_pad   [NumCoresMax];
   logic [31:0]            cycles_pad [NumCoresMax];
   core_state_e            state_pad  [NumCoresMax];
   logic [NumCoresMax-1:0] running_pad;
   logic [NumCoresMax-1:0] done_pad;
   logic [NumCoresMax-1:0] done_evt_pad;

   logic [7:0] irq_state_reg;
   logic [7:0] irq_en_reg;
   logic       irq_reg;

   logic       d_valid_reg;
   tl_d_op_e   d_opcode_reg;
   logic [1:0] d_size_reg;
   logic [7:0] d_source_reg;
   logic [31:0] d_data_reg;
   logic       d_error_reg;

   logic       accept;
   logic       is_get;
   logic       is_put;
   logic [7:0] off;
   logic [7:0] core_off;
   logic [2:0] core_idx;
   logic       per_core_hit;

   logic        req_err;
   logic [31:0] req_rdata;
   logic        wr_start;
   logic        wr_halt;
   logic        wr_irq_state;
   logic        wr_irq_en;
   logic        wr_boot;

   logic [NumCores-1:0] start_vec;
   logic [NumCores-1:0] halt_vec;
   logic [7:0]          w1c_vec;

   logic unused_tl;
   assign unused_tl = ^{tl_i.a_param, tl_i.a_address[31:8]};

   assign accept   = tl_i.a_valid && !d_valid_reg;
   assign is_get   = (tl_i.a_opcode == Get);
   assign is_put   = (tl_i.a_opcode == PutFullData) || (tl_i.a_opcode == PutPartialData);
   assign off      = tl_i.a_address[7:0];
   assign core_off = off - OffCoreBase;
   assign core_idx = core_off[5:3];
   assign per_core_hit = (off >= OffCoreBase) && (core_off[7:6] == 2'b00) &&
                         (core_off[1:0] == 2'b00) && (int'(core_idx) < NumCores);

   always_comb begin
      req_err      = 1'b0;
      req_rdata    = '0;
      wr_start     = 1'b0;
      wr_halt      = 1'b0;
      wr_irq_state = 1'b0;
      wr_irq_en    = 1'b0;
      wr_boot      = 1'b0;
      if (!(is_get || is_put)) begin
         req_err = 1'b1;
      end else if (is_put && (tl_i.a_mask != 4'hF)) begin
         req_err = 1'b1;
      end else if (per_core_hit) begin
         if (!core_off[2]) begin
            if (is_get) begin
               req_rdata = boot_pad[core_idx];
            end else if ((state_pad[core_idx] == CoreHold) ||
                         (state_pad[core_idx] == CoreRunning)) begin
               req_err = 1'b1;
            end else begin
               wr_boot = 1'b1;
            end
         end else if (is_get) begin
            req_rdata = cycles_pad[core_idx];
         end else begin
            req_err = 1'b1;
         end
      end else begin
         case (off)
            OffStart:     wr_start = is_put;
            OffHalt:      wr_halt  = is_put;
            OffStatus: begin
               if (is_get) req_rdata = {16'h0, done_pad, running_pad};
               else        req_err   = 1'b1;
            end
            OffIrqState: begin
               if (is_get) req_rdata    = {24'h0, irq_state_reg};
               else        wr_irq_state = 1'b1;
            end
            OffIrqEnable: begin
               if (is_get) req_rdata = {24'h0, irq_en_reg};
               else        wr_irq_en = 1'b1;
            end
            default:      req_err = 1'b1;
         endcase
      end
   end

   assign start_vec = (accept && wr_start)     ? tl_i.a_data[NumCores-1:0] : '0;
   assign halt_vec  = (accept && wr_halt)      ? tl_i.a_data[NumCores-1:0] : '0;
   assign w1c_vec   = (accept && wr_irq_state) ? tl_i.a_data[7:0]          : '0;

   genvar gi;
   generate
      for (gi = 0; gi < NumCoresMax; gi++) begin : g_core
         if (gi < NumCores) begin : g_on
            logic [31:2] boot_addr_reg;
            logic [31:0] cycles;
            core_state_e state;

            cluster_ctrl_core_fsm #(
               .ResetHoldCycles(ResetHoldCycles)
            ) u_fsm (
               .clk_i      (clk_i),
               .rst_i      (rst_i),
               .start_i    (start_vec[gi]),
               .halt_i     (halt_vec[gi]),
               .done_i     (core_done_i[gi]),
               .state_o    (state),
               .core_rst_no(core_rst_no[gi]),
               .done_evt_o (done_evt_pad[gi]),
               .cycles_o   (cycles)
            );

            always_ff @(posedge clk_i) begin
               if (rst_i) begin
                  boot_addr_reg <= BootAddrDefault[31:2];
               end else if (accept && wr_boot && (core_idx == 3'(gi))) begin
                  boot_addr_reg <= tl_i.a_data[31:2];
               end
            end

            assign boot_addr_o[gi] = {boot_addr_reg, 2'b00};
            assign boot_pad[gi]    = {boot_addr_reg, 2'b00};
            assign cycles_pad[gi]  = cycles;
            assign state_pad[gi]   = state;
            assign running_pad[gi] = (state == CoreRunning);
            assign done_pad[gi]    = (state == CoreDone);
         end else begin : g_off
            assign boot_pad[gi]     = '0;
            assign cycles_pad[gi]   = '0;
            assign state_pad[gi]    = CoreIdle;
            assign running_pad[gi]  = 1'b0;
            assign done_pad[gi]     = 1'b0;
            assign done_evt_pad[gi] = 1'b0;
         end
      end
   endgenerate

   // A completion in the same cycle as a W1C of that bit keeps the bit set
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         irq_state_reg <= '0;
         irq_en_reg    <= '0;
         irq_reg       <= 1'b0;
      end else begin
         irq_state_reg <= ((irq_state_reg & ~w1c_vec) | done_evt_pad) & CoreMask;
         if (accept && wr_irq_en) begin
            irq_en_reg <= tl_i.a_data[7:0] & CoreMask;
         end
         irq_reg <= |(irq_state_reg & irq_en_reg);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         d_valid_reg  <= 1'b0;
         d_opcode_reg <= AccessAck;
         d_size_reg   <= '0;
         d_source_reg <= '0;
         d_data_reg   <= '0;
         d_error_reg  <= 1'b0;
      end else if (accept) begin
         d_valid_reg  <= 1'b1;
         d_opcode_reg <= is_get ? AccessAckData : AccessAck;
         d_size_reg   <= tl_i.a_size;
         d_source_reg <= tl_i.a_source;
         d_data_reg   <= req_err ? 32'h0 : req_rdata;
         d_error_reg  <= req_err;
      end else if (d_valid_reg && tl_i.d_ready) begin
         d_valid_reg <= 1'b0;
      end
   end

   always_comb begin
      tl_o          = '0;
      tl_o.d_valid  = d_valid_reg;
      tl_o.d_opcode = d_opcode_reg;
      tl_o.d_size   = d_size_reg;
      tl_o.d_source = d_source_reg;
      tl_o.d_data   = d_data_reg;
      tl_o.d_error  = d_error_reg;
      tl_o.a_ready  = !d_valid_reg;
   end

   assign irq_o = irq_reg;

endmodule

// File: tb/tb_cluster_ctrl.sv
// Directed and randomized register-port checks of cluster_ctrl against a
// small register-map reference model (NumCores=2, hold of 16 cycles).
module tb_cluster_ctrl;
   import tlul_pkg::*;

   localparam int HOLD = 16;

   logic            clk;
   logic            rst;
   tl_h2d_t         tl_h;
   tl_d2h_t         tl_d;
   logic [1:0]      core_rst_n;
   logic [1:0][31:0] boot_addr;
   logic [1:0]      core_done;
   logic            irq;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   logic [7:0] src_cnt = 8'h0;

   // Reference model of the software-visible register state
   logic [31:0] m_boot [2];
   logic [1:0]  m_en;

   cluster_ctrl #(
      .NumCores       (2),
      .ResetHoldCycles(HOLD),
      .BootAddrDefault(32'h0)
   ) dut (
      .clk_i      (clk),
      .rst_i      (rst),
      .tl_i       (tl_h),
      .tl_o       (tl_d),
      .core_rst_no(core_rst_n),
      .boot_addr_o(boot_addr),
      .core_done_i(core_done),
      .irq_o      (irq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Called at a negedge; returns at the negedge after the accepting edge.
   task automatic tl_xfer(input logic wr, input logic [7:0] off, input logic [31:0] data,
                          input logic [3:0] mask, output logic [31:0] rdata, output logic err);
      int n = 0;
      logic [7:0] src = src_cnt;
      src_cnt++;
      tl_h.a_valid   = 1'b1;
      tl_h.a_opcode  = wr ? PutFullData : Get;
      tl_h.a_address = {24'h0, off};
      tl_h.a_data    = data;
      tl_h.a_mask    = mask;
      tl_h.a_size    = 2'd2;
      tl_h.a_source  = src;
      while (tl_d.a_ready !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("a_ready_wait", {31'b0, tl_d.a_ready}, 32'd1);
      @(posedge clk);
      @(negedge clk);
      tl_h.a_valid = 1'b0;
      chk("d_valid", {31'b0, tl_d.d_valid}, 32'd1);
      chk("d_source", {24'b0, tl_d.d_source}, {24'b0, src});
      chk("d_opcode", {29'b0, tl_d.d_opcode}, wr ? {29'b0, AccessAck} : {29'b0, AccessAckData});
      rdata = tl_d.d_data;
      err   = tl_d.d_error;
      $display("xfer %s off=%h data=%h mask=%h -> rdata=%h err=%0b",
               wr ? "W" : "R", off, data, mask, rdata, err);
   endtask

   task automatic wait_running(input int idx);
      int n = 0;
      while (core_rst_n[idx] !== 1'b1 && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("run_wait", {31'b0, core_rst_n[idx]}, 32'd1);
   endtask

   initial begin
      logic [31:0] rd;
      logic        er;
      logic [31:0] held;
      logic [7:0]  offs [14];
      logic [7:0]  off;
      logic        wr;
      logic [31:0] data;
      logic [3:0]  mask;
      logic [31:0] exp_rd;
      logic        exp_err;
      int          t0;

      offs = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h14, 8'h20, 8'h24,
               8'h28, 8'h2C, 8'h30, 8'h34, 8'h40, 8'h22};
      m_boot[0] = 32'h0;
      m_boot[1] = 32'h0;
      m_en      = 2'b00;
      tl_h = '0;
      tl_h.d_ready = 1'b1;
      core_done = 2'b00;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_core_rst_n", {30'b0, core_rst_n}, 32'd0);
      chk("rst_d_valid", {31'b0, tl_d.d_valid}, 32'd0);
      chk("rst_irq", {31'b0, irq}, 32'd0);
      chk("rst_boot1", boot_addr[1], 32'h0);
      rst = 1'b0;
      @(negedge clk);

      // START core 0: reset held low exactly HOLD cycles, then released
      tl_xfer(1'b1, 8'h10, 32'h1, 4'hF, rd, er);
      m_en = 2'b01;
      chk("irq_en_err", {31'b0, er}, 32'd0);
      tl_xfer(1'b1, 8'h00, 32'h1, 4'hF, rd, er);
      chk("start_err", {31'b0, er}, 32'd0);
      for (int i = 0; i < HOLD; i++) begin
         chk("hold_low", {31'b0, core_rst_n[0]}, 32'd0);
         @(negedge clk);
      end
      chk("hold_release", {31'b0, core_rst_n[0]}, 32'd1);
      t0 = cyc;
      tl_xfer(1'b0, 8'h08, 32'h0, 4'hF, rd, er);
      chk("status_run", rd, 32'h0001);

      // Completion in the 100th run cycle
      while (cyc - t0 < 99) @(negedge clk);
      core_done[0] = 1'b1;
      @(negedge clk);
      core_done[0] = 1'b0;
      chk("irq_lag", {31'b0, irq}, 32'd0);
      chk("done_rst_low", {31'b0, core_rst_n[0]}, 32'd0);
      @(negedge clk);
      chk("irq_high", {31'b0, irq}, 32'd1);
      tl_xfer(1'b0, 8'h08, 32'h0, 4'hF, rd, er);
      chk("status_done", rd, 32'h0100);
      tl_xfer(1'b0, 8'h24, 32'h0, 4'hF, rd, er);
      chk("cycles0", rd, 32'd100);
      tl_xfer(1'b0, 8'h0C, 32'h0, 4'hF, rd, er);
      chk("irq_state", rd, 32'h1);
      tl_xfer(1'b1, 8'h0C, 32'h1, 4'hF, rd, er);
      @(negedge clk);
      chk("irq_cleared", {31'b0, irq}, 32'd0);
      tl_xfer(1'b0, 8'h0C, 32'h0, 4'hF, rd, er);
      chk("irq_state_clr", rd, 32'h0);

      // HALT and completion in the same cycle: halt wins, no interrupt
      tl_xfer(1'b1, 8'h00, 32'h1, 4'hF, rd, er);
      wait_running(0);
      @(negedge clk);
      core_done[0] = 1'b1;
      tl_xfer(1'b1, 8'h04, 32'h1, 4'hF, rd, er);
      core_done[0] = 1'b0;
      chk("halt_rst_low", {31'b0, core_rst_n[0]}, 32'd0);
      tl_xfer(1'b0, 8'h08, 32'h0, 4'hF, rd, er);
      chk("halt_status", rd, 32'h0);
      tl_xfer(1'b0, 8'h0C, 32'h0, 4'hF, rd, er);
      chk("halt_irq_state", rd, 32'h0);
      chk("halt_irq", {31'b0, irq}, 32'd0);

      // BOOT_ADDR writes locked while core 1 runs
      tl_xfer(1'b1, 8'h00, 32'h2, 4'hF, rd, er);
      wait_running(1);
      tl_xfer(1'b1, 8'h28, 32'h1000_0003, 4'hF, rd, er);
      chk("boot_locked_err", {31'b0, er}, 32'd1);
      tl_xfer(1'b0, 8'h28, 32'h0, 4'hF, rd, er);
      chk("boot_locked_val", rd, m_boot[1]);
      tl_xfer(1'b1, 8'h04, 32'h2, 4'hF, rd, er);
      tl_xfer(1'b1, 8'h28, 32'h1000_0003, 4'hF, rd, er);
      m_boot[1] = 32'h1000_0000;
      chk("boot_idle_err", {31'b0, er}, 32'd0);
      tl_xfer(1'b0, 8'h28, 32'h0, 4'hF, rd, er);
      chk("boot_idle_val", rd, m_boot[1]);
      chk("boot_o1", boot_addr[1], m_boot[1]);

      // Unmapped core window and partial-mask write
      tl_xfer(1'b0, 8'h30, 32'h0, 4'hF, rd, er);
      chk("unmapped_err", {31'b0, er}, 32'd1);
      chk("unmapped_rdata", rd, 32'h0);
      tl_xfer(1'b1, 8'h10, 32'h0, 4'h3, rd, er);
      chk("mask_err", {31'b0, er}, 32'd1);
      tl_xfer(1'b0, 8'h10, 32'h0, 4'hF, rd, er);
      chk("mask_no_effect", rd, {30'b0, m_en});

      // Response held under back-pressure
      @(negedge clk);
      tl_h.d_ready   = 1'b0;
      tl_h.a_valid   = 1'b1;
      tl_h.a_opcode  = Get;
      tl_h.a_address = 32'h28;
      tl_h.a_mask    = 4'hF;
      @(posedge clk);
      @(negedge clk);
      tl_h.a_valid = 1'b0;
      held = tl_d.d_data;
      chk("bp_data", held, m_boot[1]);
      for (int i = 0; i < 5; i++) begin
         chk("bp_valid", {31'b0, tl_d.d_valid}, 32'd1);
         chk("bp_stable", tl_d.d_data, held);
         chk("bp_a_ready", {31'b0, tl_d.a_ready}, 32'd0);
         @(negedge clk);
      end
      tl_h.d_ready = 1'b1;
      @(negedge clk);
      chk("bp_release", {31'b0, tl_d.d_valid}, 32'd0);

      // Randomized register traffic with all cores idle
      for (int it = 0; it < 40; it++) begin
         off  = offs[$urandom_range(0, 13)];
         wr   = 1'($urandom_range(0, 1));
         if (off == 8'h00 || off == 8'h04) wr = 1'b0;
         if (off == 8'h24 || off == 8'h2C) wr = 1'b1;
         data = $urandom;
         mask = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'hF;
         exp_rd  = 32'h0;
         exp_err = 1'b0;
         if (wr && mask != 4'hF) begin
            exp_err = 1'b1;
         end else begin
            case (off)
               8'h00, 8'h04, 8'h0C: exp_rd = 32'h0;
               8'h08: exp_err = wr;
               8'h10: begin
                  if (wr) m_en = data[1:0];
                  else    exp_rd = {30'b0, m_en};
               end
               8'h20, 8'h28: begin
                  if (wr) m_boot[off[3]] = {data[31:2], 2'b00};
                  else    exp_rd = m_boot[off[3]];
               end
               default: exp_err = 1'b1;
            endcase
         end
         tl_xfer(wr, off, data, mask, rd, er);
         chk("rand_err", {31'b0, er}, {31'b0, exp_err});
         chk("rand_rdata", rd, exp_rd);
         if (it % 8 == 7) begin
            chk("rand_boot_o0", boot_addr[0], m_boot[0]);
            chk("rand_boot_o1", boot_addr[1], m_boot[1]);
            chk("rand_irq", {31'b0, irq}, 32'd0);
         end
      end

      // Reset while both cores run and a response is pending
      tl_xfer(1'b1, 8'h00, 32'h3, 4'hF, rd, er);
      wait_running(0);
      @(negedge clk);
      tl_h.d_ready   = 1'b0;
      tl_h.a_valid   = 1'b1;
      tl_h.a_opcode  = Get;
      tl_h.a_address = 32'h08;
      tl_h.a_mask    = 4'hF;
      @(posedge clk);
      @(negedge clk);
      tl_h.a_valid = 1'b0;
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("mrst_d_valid", {31'b0, tl_d.d_valid}, 32'd0);
      chk("mrst_core_rst_n", {30'b0, core_rst_n}, 32'd0);
      chk("mrst_boot1", boot_addr[1], 32'h0);
      rst = 1'b0;
      tl_h.d_ready = 1'b1;
      @(negedge clk);
      tl_xfer(1'b0, 8'h08, 32'h0, 4'hF, rd, er);
      chk("mrst_status", rd, 32'h0);
      tl_xfer(1'b0, 8'h10, 32'h0, 4'hF, rd, er);
      chk("mrst_irq_en", rd, 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/cluster_ctrl.md
CLUSTER_CTRL -- requirements
Module: cluster_ctrl

Interface
REQ-001 SHALL have parameter NumCores, default 2, number of managed vector cores (legal 1..8).
REQ-002 SHALL have parameter ResetHoldCycles, default 16, number of cycles core reset is held after a start (legal 2..255).
REQ-003 SHALL have parameter BootAddrDefault, default 32'h0, reset value of every BOOT_ADDR register.
REQ-004 SHALL have port clk_i, input, 1, the single block clock; all logic is in this one clock domain.
REQ-005 SHALL have port rst_i, input, 1, reset; reset is synchronous and active-high.
REQ-006 SHALL have port tl_i, input, tlul_pkg::tl_h2d_t, register-port request from the management peripherals crossbar.
REQ-007 SHALL have port tl_o, output, tlul_pkg::tl_d2h_t, register-port response.
REQ-008 SHALL have port core_rst_no, output, NumCores, per-core active-low reset.
REQ-009 SHALL have port boot_addr_o, output, NumCores x 32, per-core boot address.
REQ-010 SHALL have port core_done_i, input, NumCores, per-core completion flag.
REQ-011 SHALL have port irq_o, output, 1, completion interrupt to the management core.

Function
REQ-012 SHALL use this register map (byte offsets): 0x00 START (WO); 0x04 HALT (WO); 0x08 STATUS (RO: bits[7:0] running, bits[15:8] done); 0x0C IRQ_STATE (RW1C); 0x10 IRQ_ENABLE (RW); 0x20+8n BOOT_ADDR[n] (RW, bits[1:0] read 0); 0x24+8n CYCLES[n] (RO).
REQ-013 SHALL set a_ready = !d_valid and accept at most one request at a time.
REQ-014 SHALL assert d_valid the cycle after an a_valid && a_ready handshake, echoing d_source and d_size; AccessAckData for Get, AccessAck for Put.
REQ-015 SHALL hold d_valid and all d_* fields stable until d_ready is high.
REQ-016 SHALL apply write side effects in the acceptance cycle, so they are visible from the next cycle.
REQ-017 SHALL return d_error=1 with no side effect for: an unmapped offset; a write with a_mask != 4'hF; a write to a RO register; a write to BOOT_ADDR[n] while core n is in HOLD or RUNNING.
REQ-018 SHALL return rdata 0 for write-only registers and for any errored read.
REQ-019 SHALL run one FSM per core with states IDLE, HOLD, RUNNING and DONE.
REQ-020 SHALL drive core_rst_no[n]=1 only in RUNNING.
REQ-021 SHALL move IDLE or DONE to HOLD on START bit n, clear CYCLES[n] and load the hold counter; START is ignored in HOLD or RUNNING.
REQ-022 SHALL move HOLD to RUNNING after exactly ResetHoldCycles cycles in HOLD.
REQ-023 SHALL, in RUNNING, increment CYCLES[n] every cycle, saturating at 32'hFFFF_FFFF.
REQ-024 SHALL move RUNNING to DONE on any cycle with core_done_i[n]=1, and set IRQ_STATE[n] in that transition; core_done_i is ignored in other states.
REQ-025 SHALL move any state to IDLE on HALT bit n, without setting IRQ_STATE; HALT has priority over START and core_done_i in the same cycle.
REQ-026 SHALL let a hardware set of IRQ_STATE win over a simultaneous W1C to the same bit.
REQ-027 SHALL drive irq_o = |(IRQ_STATE & IRQ_ENABLE), registered, so it asserts 1 cycle after the state change.
REQ-028 SHALL drive boot_addr_o[n] directly from BOOT_ADDR[n] with bits[1:0] forced 0.
REQ-029 SHALL read 0 at bits for cores n >= NumCores, ignore writes to those bits, and treat their per-core offsets as unmapped.

Reset
REQ-030 SHALL, when rst_i=1, at the next clock edge set: all FSMs to IDLE, core_rst_no=0, BOOT_ADDR=BootAddrDefault, CYCLES=0, IRQ_STATE=0, IRQ_ENABLE=0, irq_o=0, d_valid=0.
REQ-031 SHALL, on reset mid-transaction, drop any pending response; on reset mid-run, return the core to IDLE with its reset asserted.

Structure
REQ-032 SHALL place register offsets, the core-state enum and the NumCoresMax=8 constant in package cluster_ctrl_pkg.
REQ-033 SHALL implement the per-core FSM, hold counter and cycle counter as sub-module cluster_ctrl_core_fsm, instantiated NumCores times by a generate loop.

Verification
REQ-034 SHALL cover: write START=0x1 -> core_rst_no[0] low for 16 cycles then high; STATUS reads 0x0001.
REQ-035 SHALL cover: core 0 running 100 cycles, core_done_i[0] pulse -> STATUS=0x0100, CYCLES[0]=100, IRQ_STATE=0x1; with IRQ_ENABLE=0x1, irq_o high next cycle.
REQ-036 SHALL cover: HALT=0x1 and core_done_i[0] in the same cycle -> IDLE, IRQ_STATE stays 0.
REQ-037 SHALL cover: write BOOT_ADDR[1]=0x1000_0003 while core 1 is RUNNING -> d_error=1 and value unchanged; while IDLE -> reads 0x1000_0000.
REQ-038 SHALL cover: read offset 0x30 with NumCores=2 -> d_error=1, rdata=0; write with mask 4'h3 -> d_error=1.
REQ-039 SHALL cover: d_ready held low for 5 cycles -> d_valid and d_data stable and a_ready=0 throughout.
